uart_rx_core: RTL and testbench

Avalon-MM–readable UART receiver, the receive-side counterpart of the existing transmit core. Deserialises 8N1 frames from `uart_rxd_i`, buffers received bytes in a small FIFO, and exposes data, status and control registers on a 4-bit-address Avalon-MM slave. It sits between the board RX pin and the system bus master.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rxd.sv | 114 +++++++++++
 rtl/uart_rx_core.sv | 116 +++++++++++
 tb/tb_uart_rx_core.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// Avalon register addresses and STATUS/CTRL bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_LEVEL_LSB = 4;

    localparam int CTRL_CLR_FERR = 0;
    localparam int CTRL_CLR_OVR  = 1;
    localparam int CTRL_FLUSH    = 2;

endpackage

// File: rtl/uart_rxd.sv
// 8N1 deserialiser: input synchronizer, mid-bit baud counter and receive FSM.
// Emits one-cycle valid / frame_err pulses at the stop-bit sample.
module uart_rxd
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 868
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rxd_i,
    output logic [7:0] d_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);

    logic [1:0]       sync_q;
    logic             rxd_s;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             bit_tick;

    // Both stages reset high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    assign rxd_s    = sync_q[1];
    assign bit_tick = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        valid_o     = 1'b0;
        frame_err_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!bit_tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxd_s) begin
                    state_d = DATA;
                    cnt_d   = FULL_LOAD;
                    idx_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!bit_tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d[idx_q] = rxd_s;
                    cnt_d          = FULL_LOAD;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!bit_tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxd_s) begin
                    valid_o = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_err_o = 1'b1;
                    state_d     = BRK;
                end
            end
            // A held-low line must return high before another start bit counts.
            BRK: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign d_o = shreg_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver with a small receive FIFO, sticky error flags and an
// Avalon-MM slave exposing DATA / STATUS / CTRL registers plus an IRQ.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic [3:0] avms_address_i,
    input  logic       avms_read_i,
    input  logic       avms_write_i,
    input  logic [7:0] avms_writedata_i,
    output logic [7:0] avms_readdata_o,
    input  logic       uart_rxd_i,
    output logic       irq_o
);

    localparam int BIT_CYCLES = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    logic [7:0]   rx_d;
    logic         rx_valid, rx_ferr;
    logic [7:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic [3:0]   level4;
    logic         empty, full, rd_data, wr_ctrl, pop, push_ok, flush;
    logic         frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [7:0]   readdata_q, readdata_d, status;
    logic         irq_q, irq_d;
    logic         wdata_unused;

    uart_rxd #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rxd (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .rxd_i       (uart_rxd_i),
        .d_o         (rx_d),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    assign level   = wr_ptr_q - rd_ptr_q;
    assign level4  = 4'(level);
    assign empty   = (level == '0);
    assign full    = (level == (PTR_W + 1)'(FIFO_DEPTH));
    assign rd_data = avms_read_i && (avms_address_i == ADDR_DATA);
    assign wr_ctrl = avms_write_i && (avms_address_i == ADDR_CTRL);
    assign flush   = wr_ctrl && avms_writedata_i[CTRL_FLUSH];
    assign pop     = rd_data && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = rx_valid && (!full || pop);
    assign status  = {level4, overrun_q, frame_err_q, full, !empty};
    assign wdata_unused = ^avms_writedata_i[7:3];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Setting takes priority over a same-cycle software clear.
        frame_err_d = rx_ferr ||
                      (frame_err_q && !(wr_ctrl && avms_writedata_i[CTRL_CLR_FERR]));
        overrun_d   = (rx_valid && full && !pop) ||
                      (overrun_q && !(wr_ctrl && avms_writedata_i[CTRL_CLR_OVR]));

        readdata_d = readdata_q;
        if (avms_read_i) begin
            case (avms_address_i)
                ADDR_DATA:   readdata_d = empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
                ADDR_STATUS: readdata_d = status;
                default:     readdata_d = 8'h00;
            endcase
        end

        irq_d = (wr_ptr_d != rd_ptr_d) || frame_err_d || overrun_d;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            readdata_q  <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_d;
        end
    end

    assign avms_readdata_o = readdata_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 16 clocks per bit: a table of single
// frames plus hand-written overrun, glitch, break, reset and full-FIFO sequences.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int BITC  = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       arstN = 1'b0;
    logic [3:0] address = '0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] writeData = '0;
    logic [7:0] readData;
    logic       rxd = 1'b1;
    logic       irq;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] scoreboard [$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] expStatus;
        logic       expIrq;
    } vec_t;
    vec_t vecs [6];

    uart_rx_core #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .arst_n_i         (arstN),
        .avms_address_i   (address),
        .avms_read_i      (read),
        .avms_write_i     (write),
        .avms_writedata_i (writeData),
        .avms_readdata_o  (readData),
        .uart_rxd_i       (rxd),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Sends one 8N1 frame; the line is left at the stop-bit level afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = bits[i];
            repeat (BITC - 1) @(negedge clk);
        end
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [7:0] data);
        @(negedge clk);
        address = addr;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        data = readData;
    endtask

    task automatic writeReg(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        address   = addr;
        writeData = data;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic checkStatus(input string name, input logic [7:0] exp);
        logic [7:0] got;
        readReg(ADDR_STATUS, got);
        checkOutput(name, got, exp);
    endtask

    task automatic readDataReg(input string name);
        logic [7:0] exp, got;
        exp = (scoreboard.size() > 0) ? scoreboard.pop_front() : 8'h00;
        readReg(ADDR_DATA, got);
        checkOutput(name, got, exp);
    endtask

    task automatic sendAndModel(input logic [7:0] data);
        if (scoreboard.size() < DEPTH) scoreboard.push_back(data);
        applyStimulus(data, 1'b1);
    endtask

    initial begin
        logic [7:0] got;

        vecs[0] = '{8'h55, 8'h11, 1'b1};
        vecs[1] = '{8'h00, 8'h11, 1'b1};
        vecs[2] = '{8'hFF, 8'h11, 1'b1};
        vecs[3] = '{8'h80, 8'h11, 1'b1};
        vecs[4] = '{8'h01, 8'h11, 1'b1};
        vecs[5] = '{8'hA5, 8'h11, 1'b1};

        repeat (3) @(negedge clk);
        arstN = 1'b1;
        @(negedge clk);
        checkOutput("reset_readdata", readData, 8'h00);
        checkOutput("reset_irq", {7'd0, irq}, 8'h00);
        checkStatus("reset_status", 8'h00);
        readDataReg("empty_data_read");

        for (int v = 0; v < 6; v++) begin
            sendAndModel(vecs[v].data);
            checkStatus($sformatf("vec%0d_status", v), vecs[v].expStatus);
            checkOutput($sformatf("vec%0d_irq", v), {7'd0, irq}, {7'd0, vecs[v].expIrq});
            readDataReg($sformatf("vec%0d_data", v));
            checkStatus($sformatf("vec%0d_status_after", v), 8'h00);
            checkOutput($sformatf("vec%0d_irq_after", v), {7'd0, irq}, 8'h00);
        end

        // Overrun: five frames into a four-entry FIFO.
        for (int b = 1; b <= 5; b++) sendAndModel(8'(b));
        checkStatus("overrun_status", 8'h4B);
        for (int r = 0; r < 4; r++) readDataReg($sformatf("overrun_data%0d", r));
        checkStatus("overrun_drained", 8'h08);
        checkOutput("overrun_irq", {7'd0, irq}, 8'h01);
        writeReg(ADDR_CTRL, 8'h02);
        checkStatus("overrun_cleared", 8'h00);

        // Short low glitch must not start a frame.
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        checkStatus("glitch_status", 8'h00);
        checkOutput("glitch_irq", {7'd0, irq}, 8'h00);

        // Framing error followed by a held-low break.
        applyStimulus(8'hA5, 1'b0);
        repeat (24) @(negedge clk);
        checkStatus("break_status", 8'h04);
        checkOutput("break_irq", {7'd0, irq}, 8'h01);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        checkStatus("break_no_retrigger", 8'h04);
        writeReg(ADDR_CTRL, 8'h01);
        checkStatus("ferr_cleared", 8'h00);
        checkOutput("ferr_irq_cleared", {7'd0, irq}, 8'h00);

        // Reset in the middle of the data bits of 0x3C.
        @(negedge clk);
        rxd = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = 8'h3C >> i;
            repeat (BITC) @(negedge clk);
        end
        #2 arstN = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        arstN = 1'b1;
        checkOutput("midreset_readdata", readData, 8'h00);
        checkStatus("midreset_status", 8'h00);
        sendAndModel(8'h7E);
        checkStatus("after_reset_status", 8'h11);
        readDataReg("after_reset_data");
        checkStatus("after_reset_empty", 8'h00);

        // Flush and an unmapped address.
        sendAndModel(8'h21);
        sendAndModel(8'h22);
        checkStatus("flush_pre_status", 8'h21);
        readReg(4'h7, got);
        checkOutput("unmapped_read", got, 8'h00);
        writeReg(ADDR_CTRL, 8'h04);
        scoreboard.delete();
        checkStatus("flush_status", 8'h00);
        checkOutput("flush_irq", {7'd0, irq}, 8'h00);

        // Full FIFO: a DATA read coincides with the push of 0x99 at the stop sample.
        for (int b = 0; b < 4; b++) sendAndModel(8'h10 + 8'(b));
        checkStatus("full_status", 8'h43);
        scoreboard.push_back(8'h99);
        fork
            applyStimulus(8'h99, 1'b1);
            begin
                logic [7:0] exp;
                @(negedge clk);
                repeat (10 * BITC - 6) @(posedge clk);
                @(negedge clk);
                address = ADDR_DATA;
                read    = 1'b1;
                exp     = scoreboard.pop_front();
                @(negedge clk);
                read = 1'b0;
                checkOutput("simul_pop_data", readData, exp);
            end
        join
        checkStatus("simul_no_overrun", 8'h43);
        for (int r = 0; r < 4; r++) readDataReg($sformatf("simul_data%0d", r));
        checkStatus("simul_final_status", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
